// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction fetch over req/ready + rvalid,
// one-entry response buffer for decode stalls, and the IF/ID pipeline register.
//
// state | meaning
// IDLE  | no request in flight; may issue a fetch for PCF
// WAIT  | request accepted, response for PCF pending
// DROP  | request in flight was redirected away; next response is discarded
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     instr_id_q, instr_id_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [XLEN-1:0] pcplus4_id_q, pcplus4_id_d;
    logic            valid_id_q, valid_id_d;

    logic            handshake;
    logic            resp_ok;
    logic [XLEN-1:0] pcf_plus4;

    // Request is masked during reset so nothing leaks out before PCF is valid.
    assign imem_req  = rst_n & (state_q == S_IDLE) & ~buf_valid_q & PCWrite & ~PCSrcE;
    assign imem_addr = pcf_q;
    assign handshake = imem_req & imem_ready;
    assign resp_ok   = (state_q == S_WAIT) & imem_rvalid & ~PCSrcE;
    assign pcf_plus4 = pcf_q + XLEN'(4);

    assign InstrD   = instr_id_q;
    assign PCD      = pc_id_q;
    assign PCPlus4D = pcplus4_id_q;
    assign ValidD   = valid_id_q;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        buf_valid_d  = buf_valid_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        instr_id_d   = instr_id_q;
        pc_id_d      = pc_id_q;
        pcplus4_id_d = pcplus4_id_q;
        valid_id_d   = valid_id_q;

        case (state_q)
            S_IDLE: if (handshake) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)  state_d = S_IDLE;
                else if (PCSrcE)  state_d = S_DROP;
            end
            S_DROP: if (imem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (PCSrcE) begin
            // Redirect wins over everything, including a decode stall.
            pcf_d       = PCTargetE;
            buf_valid_d = 1'b0;
            valid_id_d  = 1'b0;
            instr_id_d  = NOP_INSTR;
        end else begin
            if (resp_ok) pcf_d = pcf_plus4;

            if (IF_ID_Write) begin
                if (buf_valid_q) begin
                    instr_id_d   = buf_instr_q;
                    pc_id_d      = buf_pc_q;
                    pcplus4_id_d = buf_pc_q + XLEN'(4);
                    valid_id_d   = 1'b1;
                    buf_valid_d  = 1'b0;
                end else if (resp_ok) begin
                    instr_id_d   = imem_rdata;
                    pc_id_d      = pcf_q;
                    pcplus4_id_d = pcf_plus4;
                    valid_id_d   = 1'b1;
                end else begin
                    instr_id_d   = NOP_INSTR;
                    valid_id_d   = 1'b0;
                end
            end

            if (resp_ok && !(IF_ID_Write && !buf_valid_q)) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imem_rdata;
                buf_pc_d    = pcf_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pcf_q        <= RESET_PC;
            buf_valid_q  <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
            instr_id_q   <= NOP_INSTR;
            pc_id_q      <= '0;
            pcplus4_id_q <= '0;
            valid_id_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            buf_valid_q  <= buf_valid_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            instr_id_q   <= instr_id_d;
            pc_id_q      <= pc_id_d;
            pcplus4_id_q <= pcplus4_id_d;
            valid_id_q   <= valid_id_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an instruction memory responder with adjustable
// latency, and one task per scenario with hand-computed expectations.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, IF_ID_Write, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          lat    = 1;

    logic [32:0] ra, exp_ra;
    logic [96:0] ifid, exp_ifid;

    assign ra   = {imem_req, imem_addr};
    assign ifid = {ValidD, PCD, InstrD, PCPlus4D};

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    // Memory contents: word at address a is 0x00A00093 + (a << 8).
    initial begin : responder
        logic        hs;
        logic [31:0] hs_addr, pend_addr;
        int          cnt;
        cnt = 0; pend_addr = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            hs      = imem_req & imem_ready;
            hs_addr = imem_addr;
            @(posedge clk); #1;
            if (!rst_n) cnt = 0;
            else if (hs) begin cnt = lat; pend_addr = hs_addr; end
            imem_rvalid = (cnt == 1);
            imem_rdata  = (cnt == 1) ? 32'h00A0_0093 + (pend_addr << 8) : 32'hDEAD_BEEF;
            if (cnt > 0) cnt--;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        sample();
        exp_ra = {1'b0, 32'h0};
        n_chk++; if (ra !== exp_ra) $display("FAIL reset_req_addr: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b0, 32'h0, NOP, 32'h0};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL reset_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 2; i++) begin
            sample();
            exp_ra = {1'b1, 32'(4 * i)};
            n_chk++; if (ra !== exp_ra) $display("FAIL basic_req_addr%0d: got %h expected %h", i, ra, exp_ra); else n_pass++;
            if (i > 0) begin
                exp_ifid = {1'b1, 32'h0, 32'h00A0_0093, 32'h4};
                n_chk++; if (ifid !== exp_ifid) $display("FAIL basic_ifid%0d: got %h expected %h", i, ifid, exp_ifid); else n_pass++;
            end
            step();
            sample();
            n_chk++; if ({imem_req, ValidD} !== 2'b00) $display("FAIL basic_wait%0d: got req/valid %b expected 00", i, {imem_req, ValidD}); else n_pass++;
            step();
        end
    endtask

    task automatic test_stall();
        exp_ifid = {1'b1, 32'h4, 32'h00A0_0493, 32'h8};
        IF_ID_Write = 1'b0;
        sample();
        exp_ra = {1'b1, 32'h8};
        n_chk++; if (ra !== exp_ra) $display("FAIL stall_req8: got %h expected %h", ra, exp_ra); else n_pass++;
        n_chk++; if (ifid !== exp_ifid) $display("FAIL stall_ifid_a: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        PCWrite = 1'b0;
        for (int j = 0; j < 3; j++) begin
            sample();
            exp_ra = {1'b0, (j == 0) ? 32'h8 : 32'hC};
            n_chk++; if (ra !== exp_ra) $display("FAIL stall_req%0d: got %h expected %h", j, ra, exp_ra); else n_pass++;
            n_chk++; if (ifid !== exp_ifid) $display("FAIL stall_hold%0d: got %h expected %h", j, ifid, exp_ifid); else n_pass++;
            step();
        end
        PCWrite = 1'b1; IF_ID_Write = 1'b1;
        sample();
        n_chk++; if (imem_req !== 1'b0) $display("FAIL stall_buf_full_req: got %b expected 0", imem_req); else n_pass++;
        step();
        sample();
        exp_ra = {1'b1, 32'hC};
        n_chk++; if (ra !== exp_ra) $display("FAIL stall_release_req: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b1, 32'h8, 32'h00A0_0893, 32'hC};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL stall_release_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
        lat = 3;
        step();
    endtask

    task automatic test_redirect_wait();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        sample();
        n_chk++; if (imem_req !== 1'b0) $display("FAIL redir_wait_req: got %b expected 0", imem_req); else n_pass++;
        step();
        PCSrcE = 1'b0;
        exp_ifid = {1'b0, 32'h8, NOP, 32'hC};
        for (int j = 0; j < 2; j++) begin
            sample();
            exp_ra = {1'b0, 32'h100};
            n_chk++; if (ra !== exp_ra) $display("FAIL redir_drop_req%0d: got %h expected %h", j, ra, exp_ra); else n_pass++;
            n_chk++; if (ifid !== exp_ifid) $display("FAIL redir_drop_ifid%0d: got %h expected %h", j, ifid, exp_ifid); else n_pass++;
            step();
        end
        lat = 1;
        sample();
        exp_ra = {1'b1, 32'h100};
        n_chk++; if (ra !== exp_ra) $display("FAIL redir_refetch: got %h expected %h", ra, exp_ra); else n_pass++;
        n_chk++; if (ifid !== exp_ifid) $display("FAIL redir_discard_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
    endtask

    task automatic test_redirect_rvalid();
        sample();
        step();
        sample();
        exp_ra = {1'b1, 32'h104};
        n_chk++; if (ra !== exp_ra) $display("FAIL redir_rv_req104: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b1, 32'h100, 32'h00A1_0093, 32'h104};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL redir_rv_ifid100: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h100; IF_ID_Write = 1'b0;
        sample();
        step();
        PCSrcE = 1'b0; IF_ID_Write = 1'b1;
        sample();
        exp_ra = {1'b1, 32'h100};
        n_chk++; if (ra !== exp_ra) $display("FAIL redir_rv_refetch: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b0, 32'h100, NOP, 32'h104};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL redir_rv_bubble: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        sample();
        step();
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            sample();
            exp_ra = {1'b1, 32'h104};
            n_chk++; if (ra !== exp_ra) $display("FAIL rdy_low_req%0d: got %h expected %h", j, ra, exp_ra); else n_pass++;
            exp_ifid = (j == 0) ? {1'b1, 32'h100, 32'h00A1_0093, 32'h104} : {1'b0, 32'h100, NOP, 32'h104};
            n_chk++; if (ifid !== exp_ifid) $display("FAIL rdy_low_ifid%0d: got %h expected %h", j, ifid, exp_ifid); else n_pass++;
            step();
        end
        imem_ready = 1'b1;
        sample();
        step();
        sample();
        step();
    endtask

    task automatic test_wrap_and_reset();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        sample();
        exp_ra = {1'b0, 32'h108};
        n_chk++; if (ra !== exp_ra) $display("FAIL wrap_pc108: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b1, 32'h104, 32'h00A1_0493, 32'h108};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL rdy_done_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        PCSrcE = 1'b0;
        sample();
        exp_ra = {1'b1, 32'hFFFF_FFFC};
        n_chk++; if (ra !== exp_ra) $display("FAIL wrap_req_top: got %h expected %h", ra, exp_ra); else n_pass++;
        step();
        sample();
        step();
        sample();
        exp_ra = {1'b1, 32'h0};
        n_chk++; if (ra !== exp_ra) $display("FAIL wrap_req_zero: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b1, 32'hFFFF_FFFC, 32'h009F_FC93, 32'h0};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL wrap_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        #2 rst_n = 1'b0;
        #1;
        exp_ra = {1'b0, 32'h0};
        n_chk++; if (ra !== exp_ra) $display("FAIL async_rst_req: got %h expected %h", ra, exp_ra); else n_pass++;
        exp_ifid = {1'b0, 32'h0, NOP, 32'h0};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL async_rst_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
        step();
        rst_n = 1'b1;
        sample();
        exp_ra = {1'b1, 32'h0};
        n_chk++; if (ra !== exp_ra) $display("FAIL post_rst_req: got %h expected %h", ra, exp_ra); else n_pass++;
        step();
        sample();
        step();
        sample();
        exp_ifid = {1'b1, 32'h0, 32'h00A0_0093, 32'h4};
        n_chk++; if (ifid !== exp_ifid) $display("FAIL post_rst_ifid: got %h expected %h", ifid, exp_ifid); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1;
        PCSrcE = 1'b0; PCTargetE = '0; imem_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_ready_low();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
